// File: rtl/cla_pipe_adder_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
package cla_pipe_adder_pkg;

  // Supported block widths.
  localparam int unsigned CLA_BLK4 = 4;
  localparam int unsigned CLA_BLK8 = 8;

  // Per-block generate/propagate vectors, sized for the widest block. Narrower blocks
  // zero-extend into the low bits.
  typedef struct packed {
    logic [CLA_BLK8-1:0] g;
    logic [CLA_BLK8-1:0] p;
  } cla_gp_t;

  // Effective operand controls: whether b is inverted, and the carry fed into block 0.
  typedef struct packed {
    logic inv_b;
    logic cin;
  } cla_eff_t;

  // Subtraction is a + ~b + 1, so the external carry-in is ignored when sub is set.
  function automatic cla_eff_t cla_eff_ctl(input logic sub, input logic cin);
    cla_eff_t r;
    r.inv_b = sub;
    r.cin   = sub | cin;
    return r;
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLK-bit carry-lookahead block. Every internal carry is a flat
// sum-of-products of g, p and cin, so there is no ripple path inside the block.
module cla_block
  import cla_pipe_adder_pkg::*;
#(
  parameter int unsigned BLK = CLA_BLK8
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout,
  output logic           c_msb
);

  cla_gp_t        w_gp;
  logic [BLK:0]   w_c;
  logic           unused_gp;

  assign w_gp.g = CLA_BLK8'(a & b);
  assign w_gp.p = CLA_BLK8'(a ^ b);

  // The upper g/p bits are zero padding when BLK is 4.
  assign unused_gp = ^{w_gp.g, w_gp.p};

  // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin.
  always_comb begin
    logic pp;
    w_c    = '0;
    w_c[0] = cin;
    for (int i = 0; i < BLK; i++) begin
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        w_c[i+1] = w_c[i+1] | (pp & w_gp.g[j]);
        pp       = pp & w_gp.p[j];
      end
      w_c[i+1] = w_c[i+1] | (pp & cin);
    end
  end

  assign s     = w_gp.p[BLK-1:0] ^ w_c[BLK-1:0];
  assign cout  = w_c[BLK];
  assign c_msb = w_c[BLK-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor. Stage k adds block k and registers the
// partial sum plus the carry for block k+1; operands travel alongside so each block
// meets its carry in the right cycle. One global advance moves or freezes every stage.
module cla_pipe_adder
  import cla_pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLK   = CLA_BLK8,
  localparam int unsigned NSTG = WIDTH / BLK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  if ((WIDTH % BLK) != 0 || WIDTH < BLK || (BLK != CLA_BLK4 && BLK != CLA_BLK8)) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a non-zero multiple of BLK, and BLK must be 4 or 8");
  end

  cla_eff_t         w_eff;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_adv;

  // Stage inputs: stage 0 reads the ports, stage k reads the registers of stage k-1.
  logic [WIDTH-1:0] w_a_in   [NSTG];
  logic [WIDTH-1:0] w_b_in   [NSTG];
  logic [WIDTH-1:0] w_sum_in [NSTG];
  logic [WIDTH-1:0] w_sum_nxt[NSTG];
  logic [NSTG-1:0]  w_c_in;
  logic [NSTG-1:0]  w_v_in;

  logic [BLK-1:0]   w_blk_s  [NSTG];
  logic [NSTG-1:0]  w_blk_co;
  logic [NSTG-1:0]  w_blk_cm;

  logic [WIDTH-1:0] r_sum    [NSTG];
  logic [WIDTH-1:0] r_a      [NSTG];
  logic [WIDTH-1:0] r_b      [NSTG];
  logic [NSTG-1:0]  r_c;
  logic [NSTG-1:0]  r_valid;
  logic             r_cmsb;

  logic             unused_tail;

  assign w_eff   = cla_eff_ctl(sub, cin);
  assign w_b_eff = b ^ {WIDTH{w_eff.inv_b}};

  // Whole pipe moves together; a held output freezes bubbles too, so in_ready tracks it.
  assign w_adv    = !r_valid[NSTG-1] || out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam logic [WIDTH-1:0] BlkMask = WIDTH'({BLK{1'b1}}) << (k * BLK);

    if (k == 0) begin : g_first
      assign w_a_in[k]   = a;
      assign w_b_in[k]   = w_b_eff;
      assign w_sum_in[k] = '0;
      assign w_c_in[k]   = w_eff.cin;
      assign w_v_in[k]   = in_valid;
    end else begin : g_next
      assign w_a_in[k]   = r_a[k-1];
      assign w_b_in[k]   = r_b[k-1];
      assign w_sum_in[k] = r_sum[k-1];
      assign w_c_in[k]   = r_c[k-1];
      assign w_v_in[k]   = r_valid[k-1];
    end

    cla_block #(
      .BLK(BLK)
    ) u_blk (
      .a    (w_a_in[k][k*BLK +: BLK]),
      .b    (w_b_in[k][k*BLK +: BLK]),
      .cin  (w_c_in[k]),
      .s    (w_blk_s[k]),
      .cout (w_blk_co[k]),
      .c_msb(w_blk_cm[k])
    );

    // Lower sum blocks pass through; this stage drops its own block into place.
    assign w_sum_nxt[k] = (w_sum_in[k] & ~BlkMask) | (WIDTH'(w_blk_s[k]) << (k * BLK));
  end

  // Pipeline registers: shift every stage on advance, hold everything otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_c     <= '0;
      r_cmsb  <= 1'b0;
      for (int k = 0; k < NSTG; k++) begin
        r_sum[k] <= '0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
      end
    end else if (w_adv) begin
      r_valid <= w_v_in;
      r_c     <= w_blk_co;
      r_cmsb  <= w_blk_cm[NSTG-1];
      for (int k = 0; k < NSTG; k++) begin
        r_sum[k] <= w_sum_nxt[k];
        r_a[k]   <= w_a_in[k];
        r_b[k]   <= w_b_in[k];
      end
    end
  end

  // Last stage's operand copies and the inner blocks' MSB carries have no consumer.
  assign unused_tail = ^{r_a[NSTG-1], r_b[NSTG-1], w_blk_cm};

  assign out_valid = r_valid[NSTG-1];
  assign s         = r_sum[NSTG-1];
  assign cout      = r_c[NSTG-1];
  assign ovf       = r_cmsb ^ r_c[NSTG-1];
  // Qualified by valid so the flag reads 0 out of reset and on bubbles.
  assign zero      = r_valid[NSTG-1] & ~|r_sum[NSTG-1];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: an 8-bit/4-bit-block instance and a 32-bit/8-bit-block
// instance share stimulus through a select. A queue-based arithmetic model predicts
// every accepted operand set; a negedge monitor compares each valid output against it.
module tb_cla_pipe_adder;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       = 1'b1;
  logic        sel       = 1'b0;
  logic        in_valid  = 1'b0;
  logic        cin       = 1'b0;
  logic        sub       = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a         = '0;
  logic [31:0] b         = '0;

  logic        iv8, iv32, ir8, ir32, ov8, ov32, co8, co32, of8, of32, z8, z32;
  logic [7:0]  s8;
  logic [31:0] s32;
  logic        in_ready, o_valid;
  res_t        o_res;

  int   checks   = 0;
  int   failures = 0;
  int   n_acc    = 0;
  int   n_pop    = 0;
  int   cyc      = 0;
  int   pop_cyc[$];
  res_t exp_q[$];
  res_t held;
  logic held_v   = 1'b0;

  assign iv8      = in_valid & ~sel;
  assign iv32     = in_valid & sel;
  assign in_ready = sel ? ir32 : ir8;
  assign o_valid  = sel ? ov32 : ov8;

  always_comb begin
    if (sel) o_res = '{s: s32, c: co32, o: of32, z: z32};
    else     o_res = '{s: {24'b0, s8}, c: co8, o: of8, z: z8};
  end

  cla_pipe_adder #(.WIDTH(8), .BLK(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a[7:0]), .b(b[7:0]),
    .cin(cin), .sub(sub), .out_valid(ov8), .out_ready(out_ready), .s(s8), .cout(co8),
    .ovf(of8), .zero(z8)
  );

  cla_pipe_adder #(.WIDTH(32), .BLK(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov32), .out_ready(out_ready), .s(s32), .cout(co32),
    .ovf(of32), .zero(z32)
  );

  // Plain modular arithmetic; overflow from operand/result signs.
  function automatic res_t model(input logic [31:0] ta, input logic [31:0] tb,
                                 input logic tcin, input logic tsub, input int w);
    logic [63:0] m, be, full;
    res_t r;
    m    = (64'd1 << w) - 64'd1;
    be   = {32'b0, (tsub ? ~tb : tb)} & m;
    full = ({32'b0, ta} & m) + be + (tsub ? 64'd1 : {63'b0, tcin});
    r.s  = full[31:0] & m[31:0];
    r.c  = full[w];
    r.o  = (ta[w-1] == be[w-1]) && (r.s[w-1] != ta[w-1]);
    r.z  = (r.s == 32'd0);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: push on accept, compare/pop on valid output, hold-stability on stall.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("stall_hold_valid", o_valid, 1);
        if (o_valid) chk("stall_stable", o_res, held);
      end
      if (o_valid) begin
        chk("result_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("result", o_res, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_pop++;
            pop_cyc.push_back(cyc);
          end
        end
      end
      held_v = o_valid && !out_ready;
      held   = o_res;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub, sel ? 32 : 8));
        n_acc++;
      end
    end
  end

  task automatic directed(input string nm, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tcin, input logic tsub, input logic [31:0] es,
                          input logic ec, input logic eo, input logic ez);
    int n;
    out_ready = 1'b1;
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n, sel ? 3 : 1);
    chk({nm, "_s"}, o_res.s, es);
    chk({nm, "_cout"}, o_res.c, ec);
    chk({nm, "_ovf"}, o_res.o, eo);
    chk({nm, "_zero"}, o_res.z, ez);
    @(posedge clk); #1;
  endtask

  task automatic rand_ops();
    a   = $urandom();
    b   = $urandom();
    cin = 1'($urandom_range(1, 0));
    sub = 1'($urandom_range(1, 0));
  endtask

  // Feed n operand sets back to back; out_ready drops for stall_len cycles from stall_from.
  task automatic stream(input int n, input int stall_from, input int stall_len);
    int   sent = 0;
    int   ci   = 0;
    logic acc;
    rand_ops();
    in_valid = 1'b1;
    while (sent < n && ci < 1000) begin
      out_ready = !(ci >= stall_from && ci < stall_from + stall_len);
      @(negedge clk);
      acc = in_ready;
      if (!out_ready) chk("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
      ci++;
      if (acc) begin
        sent++;
        rand_ops();
      end
    end
    chk("stream_sent", sent, n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int a0, p0, n;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      chk("rst_out_valid", o_valid, 0);
      chk("rst_fields", o_res, 0);
      chk("rst_in_ready", in_ready, 1);
    end

    chk("model_pin_add8", model(32'hFF, 32'h01, 1'b0, 1'b0, 8),
        res_t'{s: 32'h0, c: 1'b1, o: 1'b0, z: 1'b1});
    chk("model_pin_sub32", model(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32),
        res_t'{s: 32'h7FFF_FFFF, c: 1'b1, o: 1'b1, z: 1'b0});

    sel = 1'b0;
    directed("add8_wrap",  32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1);
    directed("add8_cin",   32'hFF, 32'hFD, 1'b1, 1'b0, 32'hFD, 1'b1, 1'b0, 1'b0);
    directed("add8_ovf",   32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0);
    directed("sub8_borrow", 32'h00, 32'h01, 1'b1, 1'b1, 32'hFF, 1'b0, 1'b0, 1'b0);

    sel = 1'b1;
    #1;
    directed("sub32_neg",  32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    directed("sub32_ovf",  32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    directed("sub32_zero", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);

    pop_cyc.delete();
    stream(16, 1000, 0);
    drain("stream");
    chk("stream_count", pop_cyc.size(), 16);
    n = (pop_cyc.size() > 0) ? pop_cyc[pop_cyc.size()-1] - pop_cyc[0] : -1;
    chk("stream_back_to_back", n, 15);

    a0 = n_acc; p0 = n_pop;
    stream(10, 6, 3);
    drain("backpressure");
    chk("bp_accepted", n_acc - a0, 10);
    chk("bp_delivered", n_pop - p0, 10);

    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_out_valid", o_valid, 0);
    chk("rst_mid_fields", o_res, 0);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_valid) n++;
    end
    chk("rst_mid_no_ghost", n, 0);
    @(posedge clk); #1;
    directed("post_rst", 32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    drain("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "time limit expired");
  end

endmodule
